// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - state encoding and protocol byte constants for uart_bus_master
package uart_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_TX_STATUS,
    ST_TX_DATA
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command decoder driving a req/gnt/rvalid bus; optional UART_BUS_MASTER_TIMEOUT_EN
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  output logic        req_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        busy_o
);

  state_e      state, state_next;
  logic        is_read_q;
  logic        err_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        fire, tx_ready, timeout_hit, cmd_ok;
  logic [7:0]  tx_byte;

  assign cmd_ok   = (rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ);
  // A pulse in the previous cycle blocks this one, giving the 2-cycle spacing.
  assign tx_ready = !tx_busy_i && !tx_start_o;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        in_rx;
  assign in_rx = (state == ST_RX_ADDR) || (state == ST_RX_DATA);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    tmo_cnt_q <= '0;
    else if (in_rx && !rx_valid_i)  tmo_cnt_q <= tmo_cnt_q + 32'd1;
    else                            tmo_cnt_q <= '0;
  end

  assign timeout_hit = in_rx && !rx_valid_i && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  // Parameter stays referenced so the port-compatible interface lints cleanly.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      ST_IDLE:
        if (rx_valid_i) state_next = cmd_ok ? ST_RX_ADDR : ST_TX_STATUS;
      ST_RX_ADDR:
        if (timeout_hit) state_next = ST_IDLE;
        else if (rx_valid_i && byte_cnt_q == 2'd3)
          state_next = is_read_q ? ST_BUS_REQ : ST_RX_DATA;
      ST_RX_DATA:
        if (timeout_hit) state_next = ST_IDLE;
        else if (rx_valid_i && byte_cnt_q == 2'd3) state_next = ST_BUS_REQ;
      ST_BUS_REQ:
        if (gnt_i) state_next = ST_BUS_WAIT;
      ST_BUS_WAIT:
        if (rvalid_i) state_next = ST_TX_STATUS;
      ST_TX_STATUS: begin
        tx_byte = err_q ? RSP_NAK : RSP_ACK;
        if (tx_ready) begin
          fire       = 1'b1;
          state_next = (is_read_q && !err_q) ? ST_TX_DATA : ST_IDLE;
        end
      end
      ST_TX_DATA: begin
        tx_byte = rdata_q[{byte_cnt_q, 3'b000} +: 8];
        if (tx_ready) begin
          fire = 1'b1;
          if (byte_cnt_q == 2'd3) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_read_q  <= 1'b0;
      err_q      <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      tx_start_o <= fire;
      if (fire) tx_data_o <= tx_byte;
      case (state)
        ST_IDLE:
          if (rx_valid_i) begin
            // An unknown command reuses the error flag so TX_STATUS sends NAK.
            is_read_q  <= (rx_data_i == CMD_READ);
            err_q      <= !cmd_ok;
            byte_cnt_q <= '0;
          end
        ST_RX_ADDR:
          if (rx_valid_i) begin
            addr_q     <= {rx_data_i, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        ST_RX_DATA:
          if (rx_valid_i) begin
            wdata_q    <= {rx_data_i, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        ST_BUS_WAIT:
          if (rvalid_i) begin
            rdata_q    <= rdata_i;
            err_q      <= err_i;
            byte_cnt_q <= '0;
          end
        ST_TX_DATA:
          if (fire) byte_cnt_q <= byte_cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

  assign busy_o  = (state != ST_IDLE);
  assign req_o   = (state == ST_BUS_REQ);
  assign we_o    = req_o && !is_read_q;
  assign be_o    = 4'hF;
  assign addr_o  = {addr_q[31:2], 2'b00};
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - randomized self-checking bench for uart_bus_master against a transaction-level model
module tb_uart_bus_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i = 1'b0;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = 32'h0;
  logic        err_i = 1'b0;
  logic        busy_o;

  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i),
    .req_o(req_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .we_o(we_o), .be_o(be_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i), .err_i(err_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_start = -10;
  int busy_cnt = 0;
  int ph = 0;
  int cnt = 0;
  int cfg_gdly = 0;
  int cfg_rdly = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_err = 1'b0;
  logic [7:0]  tx_q[$];
  bus_t        bus_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Transmitter model: busy for a few cycles after each start pulse.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      busy_cnt  = 0;
      tx_busy_i = 1'b0;
    end else begin
      if (tx_start_o) begin
        check("tx_busy_at_start", {31'b0, tx_busy_i}, 32'd0);
        check("tx_gap", {31'b0, (cyc - last_start) >= 2}, 32'd1);
        last_start = cyc;
        tx_q.push_back(tx_data_o);
        busy_cnt = $urandom_range(1, 4);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy_i = (busy_cnt > 0);
    end
  end

  // Bus responder: grant after cfg_gdly cycles, rvalid cfg_rdly cycles after grant.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; ph = 0; cnt = 0;
    end else begin
      case (ph)
        0: if (req_o) begin
          if (cnt >= cfg_gdly) begin
            gnt_i = 1'b1;
            bus_q.push_back('{addr_o, we_o, wdata_o, be_o});
            ph = 1; cnt = 0;
          end else cnt++;
        end
        1: begin
          gnt_i = 1'b0;
          check("req_drop_after_gnt", {31'b0, req_o}, 32'd0);
          if (cnt >= cfg_rdly) begin
            rvalid_i = 1'b1; rdata_i = cfg_rdata; err_i = cfg_err; ph = 2;
          end else cnt++;
        end
        default: begin
          rvalid_i = 1'b0; err_i = 1'b0; rdata_i = $urandom; ph = 0; cnt = 0;
        end
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000 && busy_o; k++) @(negedge clk_i);
    check("idle_wait_budget", {31'b0, k < 3000}, 32'd1);
    repeat (10) @(negedge clk_i);
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int gd, input int rd, input logic [31:0] rdat, input logic e);
    logic [7:0] exp_tx[$];
    int         exp_bus;
    logic       exp_we;
    cfg_gdly = gd; cfg_rdly = rd; cfg_rdata = rdat; cfg_err = e;
    tx_q.delete(); bus_q.delete();
    exp_tx.delete();
    exp_bus = 0; exp_we = 1'b0;
    send_byte(cmd);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (cmd == 8'h01) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
      exp_bus = 1;
      exp_we  = (cmd == 8'h01);
      exp_tx.push_back(e ? 8'h15 : 8'h06);
      if (cmd == 8'h02 && !e) for (int i = 0; i < 4; i++) exp_tx.push_back(rdat[8*i +: 8]);
    end else begin
      exp_tx.push_back(8'h15);
    end
    wait_idle();
    check("bus_count", bus_q.size(), exp_bus);
    if (exp_bus == 1 && bus_q.size() == 1) begin
      check("bus_addr", bus_q[0].addr, {addr[31:2], 2'b00});
      check("bus_we", {31'b0, bus_q[0].we}, {31'b0, exp_we});
      check("bus_be", {28'b0, bus_q[0].be}, 32'hF);
      if (exp_we) check("bus_wdata", bus_q[0].wdata, data);
    end
    check("tx_count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("tx_byte%0d", i), {24'b0, tx_q[i]}, {24'b0, exp_tx[i]});
  endtask

  initial begin
    logic [7:0] c;
    int kind;
    int k;
    #2;
    check("rst_req", {31'b0, req_o}, 32'd0);
    check("rst_we", {31'b0, we_o}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_tx_data", {24'b0, tx_data_o}, 32'd0);
    check("rst_be", {28'b0, be_o}, 32'hF);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run_cmd(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 2, 0, 32'h0, 1'b0);
    run_cmd(8'h02, 32'h0000_0004, 32'h0, 1, 2, 32'h1234_5678, 1'b0);
    run_cmd(8'h02, 32'hF000_0000, 32'h0, 0, 1, 32'hAAAA_5555, 1'b1);
    run_cmd(8'h7A, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0);
    run_cmd(8'h02, 32'h0000_0003, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0);

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 4);
      if (kind < 2) c = 8'h01;
      else if (kind < 4) c = 8'h02;
      else begin
        c = 8'($urandom);
        while (c == 8'h01 || c == 8'h02) c = 8'($urandom);
      end
      run_cmd(c, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom, ($urandom_range(0, 3) == 0));
    end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    tx_q.delete(); bus_q.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (120) @(negedge clk_i);
    check("tmo_busy", {31'b0, busy_o}, 32'd0);
    check("tmo_bus", bus_q.size(), 0);
    check("tmo_tx", tx_q.size(), 0);
    run_cmd(8'h01, 32'h0000_2000, 32'h0BAD_CAFE, 1, 1, 32'h0, 1'b0);
`endif

    // Reset while a request is outstanding and never granted.
    tx_q.delete(); bus_q.delete();
    cfg_gdly = 100000;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h40);
    for (k = 0; k < 50 && !req_o; k++) @(negedge clk_i);
    check("rst_test_req_seen", {31'b0, req_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_req", {31'b0, req_o}, 32'd0);
    check("async_rst_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    cfg_gdly = 0;
    repeat (30) @(negedge clk_i);
    check("post_rst_tx", tx_q.size(), 0);
    check("post_rst_bus", bus_q.size(), 0);
    check("post_rst_busy", {31'b0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
